// File: rtl/sclk_tone_gen.sv
// sclk_tone_gen: turns a half-period count (maxcount) into a glitch-free square-wave
// speaker clock. A new maxcount is adopted only at a half-period boundary. When the
// tone stops, sclk always finishes its high half and then rests low. period_tick
// pulses once for every completed period.
// Optional feature: define SCLK_NOTE_TIMER_EN to add a note-length timer
// (note_len / note_done). The timer stops the tone after note_len full periods.
module sclk_tone_gen #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [CNT_W-1:0] maxcount,
`ifdef SCLK_NOTE_TIMER_EN
  input  logic [7:0]       note_len,
  output logic             note_done,
`endif
  output logic             sclk,
  output logic             period_tick,
  output logic             active,
  output logic [CNT_W-1:0] cur_max
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] active_max_reg, active_max_next;
  logic             sclk_reg, sclk_next;
  logic             tick_reg, tick_next;

  logic stop_req;
  logic at_end;
  logic can_start;

`ifdef SCLK_NOTE_TIMER_EN
  logic [7:0] pcnt_reg, pcnt_next;
  logic       lock_reg, lock_next;
  logic       done_reg, done_next;
  // After a finished note, a restart is blocked until EN has been seen low.
  assign can_start = EN && (maxcount != '0) && !lock_reg;
`else
  assign can_start = EN && (maxcount != '0);
`endif

  assign stop_req = !EN || (maxcount == '0);
  assign at_end   = (count_reg == active_max_reg);

  // Next-state logic for the tone sequencer.
  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    active_max_next = active_max_reg;
    sclk_next       = sclk_reg;
    tick_next       = 1'b0;
`ifdef SCLK_NOTE_TIMER_EN
    pcnt_next = pcnt_reg;
    lock_next = lock_reg;
    done_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        sclk_next  = 1'b0;
        count_next = '0;
        if (can_start) begin
          state_next      = RUN;
          active_max_next = maxcount;
`ifdef SCLK_NOTE_TIMER_EN
          pcnt_next = 8'd0;
`endif
        end
`ifdef SCLK_NOTE_TIMER_EN
        if (!EN) lock_next = 1'b0;
`endif
      end
      RUN: begin
        if (stop_req) begin
          if (!sclk_reg) begin
            // Low half: stop at once and drop any toggle that was due now.
            state_next = IDLE;
            count_next = '0;
          end else if (at_end) begin
            // High half ends on this very edge, so fall now instead of draining.
            sclk_next  = 1'b0;
            tick_next  = 1'b1;
            count_next = '0;
            state_next = IDLE;
          end else begin
            state_next = DRAIN;
            count_next = count_reg + 1'b1;
          end
        end else if (at_end) begin
          count_next      = '0;
          sclk_next       = !sclk_reg;
          active_max_next = maxcount;  // nonzero here, since there is no stop request
          if (sclk_reg) begin
            tick_next = 1'b1;
`ifdef SCLK_NOTE_TIMER_EN
            pcnt_next = pcnt_reg + 8'd1;
            if ((note_len != 8'd0) && ((pcnt_reg + 8'd1) == note_len)) begin
              state_next = IDLE;
              done_next  = 1'b1;
              lock_next  = 1'b1;
            end
`endif
          end
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      DRAIN: begin
        if (at_end) begin
          sclk_next  = 1'b0;
          tick_next  = 1'b1;
          count_next = '0;
          state_next = IDLE;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        sclk_next  = 1'b0;
        count_next = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      active_max_reg <= '0;
      sclk_reg       <= 1'b0;
      tick_reg       <= 1'b0;
`ifdef SCLK_NOTE_TIMER_EN
      pcnt_reg <= 8'd0;
      lock_reg <= 1'b0;
      done_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      active_max_reg <= active_max_next;
      sclk_reg       <= sclk_next;
      tick_reg       <= tick_next;
`ifdef SCLK_NOTE_TIMER_EN
      pcnt_reg <= pcnt_next;
      lock_reg <= lock_next;
      done_reg <= done_next;
`endif
    end
  end

  assign sclk        = sclk_reg;
  assign period_tick = tick_reg;
  assign active      = (state_reg != IDLE);
  assign cur_max     = active ? active_max_reg : '0;
`ifdef SCLK_NOTE_TIMER_EN
  assign note_done = done_reg;
`endif

endmodule

// File: doc/sclk_tone_gen.md
Name: sclk_tone_gen

Overview:
Downstream stage of the switch-to-maxcount decoder. It consumes the 16-bit half-period count and produces the square-wave speaker clock (sclk).
- Glitch-free: a new maxcount is adopted only at a half-period boundary.
- Stops cleanly: sclk always ends low.
- Exposes per-period ticks for later sequencing logic.

Parameters:
CNT_W, 16, width of maxcount, internal counter and cur_max.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  synchronous, active-high reset.
EN  input  1  tone enable (level).
maxcount  input  CNT_W  half-period length minus one, in CLK cycles; 0 = silence.
sclk  output  1  square-wave speaker clock.
period_tick  output  1  1-cycle pulse when sclk completes a full period (1->0 transition).
active  output  1  high when state != IDLE.
cur_max  output  CNT_W  latched half-period value in use; 0 in IDLE.

Behaviour:
- Reset (RST=1 at a CLK edge): state=IDLE, count=0, active_max=0, sclk=0, period_tick=0, active=0, cur_max=0. RST has priority over every other event.
- States: IDLE, RUN, DRAIN. Registered outputs; active is decoded from the registered state.
- Half-period = active_max+1 cycles; full period = 2*(active_max+1) cycles. Counter compares by equality and never exceeds active_max. active_max = 2^CNT_W-1 is legal; no overflow path.
- IDLE:
  - sclk=0, count=0.
  - If EN=1 and maxcount!=0: next state RUN, active_max<=maxcount, count<=0.
  - Otherwise stay in IDLE.
- RUN, no stop request:
  - count increments each cycle.
  - When count==active_max: count<=0 and sclk toggles.
  - At that same edge, maxcount is re-sampled. If nonzero, active_max<=maxcount, applying to the half-period that starts at that toggle; an unchanged value has no effect.
  - Mid-half-period changes to maxcount are ignored until the next toggle.
- RUN, stop request (EN=0 or maxcount==0), sampled every cycle:
  - If sclk=0: go to IDLE next cycle, count<=0. A toggle due in that cycle is suppressed.
  - If sclk=1: go to DRAIN; the counter keeps running.
  - Stop takes priority over the maxcount re-sample.
- DRAIN:
  - Counts to active_max with no re-sampling.
  - At count==active_max: sclk<=0, period_tick pulses, count<=0, state<=IDLE.
  - EN reasserting during DRAIN is ignored. IDLE re-evaluates EN on the cycle after arrival, so the minimum sclk low time after a stop is 1 cycle plus restart latency.
- period_tick: asserted in the cycle after any sclk 1->0 transition, RUN or DRAIN. Never asserted for the initial 0 level.
- cur_max mirrors active_max in RUN/DRAIN and reads 0 in IDLE.
- Start latency: EN and nonzero maxcount seen at edge t -> RUN from t+1 -> first rising edge of sclk at t+1+(maxcount+1).

Optional Feature:
Macro SCLK_NOTE_TIMER_EN.
- Defined:
  - Adds input note_len[7:0] (length in full periods) and output note_done (1-cycle pulse).
  - An internal period counter clears on IDLE->RUN and increments on each period_tick in RUN.
  - When it reaches note_len (note_len!=0): at that tick sclk is already 0, so the block goes straight to IDLE and pulses note_done in the same cycle as period_tick.
  - It then stays in IDLE, even with EN=1, until EN is seen low at least one cycle (re-arm).
  - note_len=0 means unlimited.
  - Reset clears the period counter, note_done and the re-arm lock.
- Undefined: ports absent; tone runs for as long as EN=1 and maxcount!=0.

Test Plan:
- RST=1 for 2 cycles with EN=1, maxcount=3 -> all outputs 0 throughout. Release RST -> sclk period 8 cycles (4 high/4 low), period_tick every 8 cycles, cur_max=3.
- Running at maxcount=3, switch to 5 mid-high-half -> current half completes at 4 cycles; following halves are 6 cycles; no runt pulse.
- Drop EN while sclk=1 at count=1 (maxcount=3) -> sclk stays high 2 more cycles, falls, one period_tick, active=0. Drop EN while sclk=0 -> IDLE next cycle, no period_tick.
- Set maxcount=0 while running -> same stop behaviour as EN=0. Set maxcount 0->0x0002 with EN=1 -> restart, half-period 3 cycles.
- maxcount=0xFFFF, EN=1 -> half-period 65536 cycles, counter reaches 0xFFFF and wraps to 0 at the toggle with no extra cycle.
- With SCLK_NOTE_TIMER_EN, note_len=3, maxcount=1, EN held high -> exactly 3 periods (12 cycles of sclk activity), note_done coincident with 3rd period_tick, then no restart until EN low->high.
